// File: rtl/sl_tx_arbiter.sv
// Two-requester arbiter and launch sequencer for the shared SL transmitter,
// with programmable inter-word gap and a completion watchdog.
module sl_tx_arbiter #(
    parameter int DATA_W = 32,
    parameter int GAP_W  = 8,
    parameter int TO_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              cfg_en,
    input  logic              cfg_prio,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic              err_clr,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              owner,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    // Last watchdog count before the 2^TO_W-1 limit is reached.
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t            state;
    logic [TO_W-1:0]   wd_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              last;
    logic              pick1;
    logic              done_ok;
    logic              wd_hit;

    always_comb begin
        pick1 = 1'b0;
        if (req1 && !req0)
            pick1 = 1'b1;
        else if (req0 && req1 && !cfg_prio)
            pick1 = ~last;
    end

    // A done pulse coinciding with the launch belongs to no word yet.
    assign done_ok = tx_done && !tx_start;
    assign wd_hit  = (wd_cnt == WD_LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wd_cnt   <= '0;
            gap_cnt  <= '0;
            last     <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            owner    <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            tx_start <= 1'b0;
            if (err_clr)
                err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_en && (req0 || req1)) begin
                        ack0     <= ~pick1;
                        ack1     <= pick1;
                        tx_start <= 1'b1;
                        tx_data  <= pick1 ? data1 : data0;
                        owner    <= pick1;
                        last     <= pick1;
                        wd_cnt   <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    wd_cnt <= wd_cnt + TO_W'(1);
                    if (done_ok || wd_hit) begin
                        if (!done_ok)
                            err <= 1'b1;
                        if (cfg_gap != '0) begin
                            gap_cnt <= cfg_gap;
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
